step_counter_bcd: RTL and testbench
===================================

Name: step_counter_bcd

Overview:
- Parametrised successor to the board-level loadable 4-bit counter.
- Counts debounced-edge step events from a push-button line, up or down, modulo MODULUS, with synchronous parallel load, enable, wrap or saturate mode and a terminal-count pulse.
- Serially converts the count to packed BCD (shift-add-3) for the hex_7seg digit drivers.
- Sits between KEY/SW inputs and the display path of the DE2 top level.

Parameters:
WIDTH, 8, count register width in bits
MODULUS, 200, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
DIGITS, 3, BCD digits output; 10**DIGITS must be >= MODULUS, else elaboration error
SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds

Ports:
clk  in  1  system clock (CLOCK_50 at top)
rst_n  in  1  reset; synchronous, active-low
step_in  in  1  raw push-button level, active-low (pressed = 0), asynchronous to clk
load_n  in  1  synchronous parallel load, active-low, level-sampled every clk edge
up  in  1  1 = count up, 0 = count down
en  in  1  count enable; load does not require en
d  in  WIDTH  load value
q  out  WIDTH  current count
tc  out  1  one-cycle pulse on wrap (either direction)
at_limit  out  1  level: q at bound in the current direction (MODULUS-1 if up, 0 if down)
bcd  out  4*DIGITS  packed BCD of q, digit 0 in [3:0]
bcd_valid  out  1  1 when bcd equals the current q

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - q=0, tc=0, bcd=0, bcd_valid=1.
  - Synchroniser flops=1 (released), converter IDLE, pending=0.
  - Reset mid-conversion aborts the conversion.
- Step detect:
  - 2-flop synchroniser s1,s2 plus history s3.
  - step_evt = s3 & ~s2.
  - A falling step_in first sampled at edge k gives a count update at edge k+2.
  - Holding step_in low counts exactly once; the next count requires release (s2=1) and a new press.
- Priority at each edge:
  1. load_n=0: q <= min(d, MODULUS-1), tc=0. Any coincident step_evt is discarded.
  2. en=1 and step_evt: count.
  3. Otherwise hold.
- Count up:
  - q<MODULUS-1: q+1.
  - q==MODULUS-1: wrap mode gives q=0 with tc=1 for one cycle; saturate mode holds q with tc=0.
- Count down:
  - q>0: q-1.
  - q==0: wrap mode gives q=MODULUS-1 with tc=1; saturate mode holds q.
- at_limit is combinational from q and up.
- Converter FSM (IDLE, SHIFT, DONE):
  - Any edge that changes q sets pending=1 and bcd_valid=0.
  - IDLE with pending: copy q to the shift register, clear pending, counter i=0, go to SHIFT.
  - SHIFT, one bit per edge: add 3 to each digit >=5, then shift left one bit taking the MSB of the binary register. Go to DONE after WIDTH shifts.
  - DONE: bcd <= scratch; bcd_valid <= ~pending; go to IDLE.
  - Latency: q change at edge E gives bcd/bcd_valid updated at edge E+WIDTH+2.
  - q changes during SHIFT/DONE: the current conversion completes, bcd updates but bcd_valid stays 0, then a new conversion starts from IDLE. The final bcd always matches the final q.
  - A load that leaves q unchanged does not set pending.
- No X on any output at any time; no use of initial blocks for state.

Decomposition:
- Package step_counter_pkg holds:
  - conv_state_t enum {IDLE, SHIFT, DONE}
  - ADD3_THRESH=4'd5 and ADD3_INC=4'd3
  - function clog2 for the shift counter width
- One sub-module, bcd_serial_conv (WIDTH, DIGITS, clk, rst_n, start, bin, busy, bcd, done). The counter, synchroniser and pending logic stay in the top module.

Test Plan:
- rst_n=0 for 2 cycles, then release -> q=0, bcd=12'h000, bcd_valid=1, tc=0, at_limit=0 (up=1).
- load_n=0 one cycle with d=57 -> q=57 next edge; bcd_valid=0; 10 edges later bcd=12'h057, bcd_valid=1.
- Load 199, up=1, en=1, press step_in low for 5 cycles:
  - Wrap instance: q=0 two edges after first low sample, tc high exactly one cycle, single count.
  - SATURATE=1 instance: q stays 199, tc=0, at_limit=1.
- Load 0, up=0, one press -> q=199, tc pulse, bcd=12'h199 after 10 cycles.
- Load d=250 -> q=199 (clamp). load_n=0 coincident with step_evt -> q=d, no count. en=0 with step -> q unchanged, no pending.
- Three presses spaced 4 cycles apart starting from q=8 -> bcd_valid stays 0 until the last conversion completes, then bcd=12'h011, bcd_valid=1. Assert rst_n=0 mid-SHIFT -> q=0, bcd=0, bcd_valid=1 next edge.

Source files
------------

// File: rtl/step_counter_pkg.sv
// Shared types and constants for the step counter and its serial BCD converter.
//   conv_state_t : converter FSM states
//   ADD3_THRESH  : digit value at or above which shift-add-3 adds ADD3_INC
//   clog2        : ceiling log2, used to size the converter shift counter
package step_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_INC    = 4'd3;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_serial_conv.sv
// Serial binary-to-packed-BCD converter (shift-add-3, one bit per clock).
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request; accepted only in IDLE (start is ignored while busy=1)
//   bin        : binary value captured on the accepting edge
//   busy       : converter not in IDLE
//   bcd        : registered result, digit 0 in [3:0]; updated on the DONE edge
//   done       : high during the DONE cycle, i.e. bcd is written on the next edge
// Handshake: the requester holds start until it sees busy; a conversion
// started at edge S writes bcd at edge S+WIDTH+1.
module bcd_serial_conv
    import step_counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    conv_state_t       state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BW-1:0]     scr_q, scr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [BW-1:0]     adj;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;

        // Add-3 correction so that the following left shift carries
        // correctly from one decimal digit into the next.
        adj = scr_q;
        for (int g = 0; g < DIGITS; g++) begin
            if (scr_q[4*g +: 4] >= ADD3_THRESH) begin
                adj[4*g +: 4] = scr_q[4*g +: 4] + ADD3_INC;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Top bit of adj is always zero for in-range inputs; it is dropped.
                scr_d = BW'({adj, bin_q[WIDTH-1]});
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/step_counter_bcd.sv
// Up/down modulo-MODULUS step counter driven by push-button press edges,
// with parallel load, wrap/saturate bounds and a serial BCD readout.
//   clk, rst_n : clock, synchronous active-low reset
//   step_in    : raw active-low button level (asynchronous)
//   load_n     : synchronous load, active-low, wins over counting
//   up, en     : direction and count enable
//   d          : load value (clamped to MODULUS-1)
//   q, tc      : count and one-cycle wrap pulse
//   at_limit   : q sits at the bound in the current direction
//   bcd        : packed BCD of q; bcd_valid says it matches the current q
module step_counter_bcd
    import step_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 200,
    parameter int DIGITS   = 3,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step_in,
    input  logic                  load_n,
    input  logic                  up,
    input  logic                  en,
    input  logic [WIDTH-1:0]      d,
    output logic [WIDTH-1:0]      q,
    output logic                  tc,
    output logic                  at_limit,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid
);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("step_counter_bcd: MODULUS out of range for WIDTH");
    end
    if ((10 ** DIGITS) < MODULUS) begin : g_bad_digits
        $error("step_counter_bcd: DIGITS too small to display MODULUS-1");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              tc_q, tc_d;
    logic              pending_q, pending_d;
    logic              bcd_valid_q, bcd_valid_d;
    logic              step_evt;
    logic              q_changed;
    logic              conv_start;
    logic              conv_busy;
    logic              conv_done;

    // Synchronised level went from released (1) to pressed (0).
    assign step_evt = s3_q & ~s2_q;

    always_comb begin
        s1_d = step_in;
        s2_d = s1_q;
        s3_d = s2_q;
        q_d  = q_q;
        tc_d = 1'b0;

        if (!load_n) begin
            q_d = (d > MAXV) ? MAXV : d;
        end else if (en && step_evt) begin
            if (up) begin
                if (q_q != MAXV) begin
                    q_d = q_q + 1'b1;
                end else if (SATURATE == 0) begin
                    q_d  = '0;
                    tc_d = 1'b1;
                end
            end else begin
                if (q_q != '0) begin
                    q_d = q_q - 1'b1;
                end else if (SATURATE == 0) begin
                    q_d  = MAXV;
                    tc_d = 1'b1;
                end
            end
        end

        q_changed  = (q_d != q_q);
        conv_start = pending_q & ~conv_busy;

        // A change on the same edge as a start keeps pending set, so the
        // conversion just launched (with the old q) is followed by another.
        pending_d = pending_q;
        if (q_changed) begin
            pending_d = 1'b1;
        end else if (conv_start) begin
            pending_d = 1'b0;
        end

        bcd_valid_d = bcd_valid_q;
        if (q_changed) begin
            bcd_valid_d = 1'b0;
        end else if (conv_done) begin
            bcd_valid_d = ~pending_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            s3_q        <= 1'b1;
            q_q         <= '0;
            tc_q        <= 1'b0;
            pending_q   <= 1'b0;
            bcd_valid_q <= 1'b1;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            q_q         <= q_d;
            tc_q        <= tc_d;
            pending_q   <= pending_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    bcd_serial_conv #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (q_q),
        .busy  (conv_busy),
        .bcd   (bcd),
        .done  (conv_done)
    );

    assign q         = q_q;
    assign tc        = tc_q;
    assign at_limit  = up ? (q_q == MAXV) : (q_q == '0);
    assign bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_step_counter_bcd.sv
module tb_step_counter_bcd;

    localparam int WIDTH   = 8;
    localparam int MODULUS = 200;
    localparam int DIGITS  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, step_in, load_n, up, en;
    logic [WIDTH-1:0] d;

    logic [WIDTH-1:0]    q_w, q_s;
    logic                tc_w, tc_s, al_w, al_s, bv_w, bv_s;
    logic [4*DIGITS-1:0] bcd_w, bcd_s;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one count per instance (0 = wrap, 1 = saturate),
    // plus the history of step_in as seen at each clock edge.
    int m_q[2];
    bit m_tc[2];
    bit samp[$];

    step_counter_bcd #(.WIDTH(WIDTH), .MODULUS(MODULUS), .DIGITS(DIGITS), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .step_in(step_in), .load_n(load_n), .up(up), .en(en), .d(d),
        .q(q_w), .tc(tc_w), .at_limit(al_w), .bcd(bcd_w), .bcd_valid(bv_w)
    );

    step_counter_bcd #(.WIDTH(WIDTH), .MODULUS(MODULUS), .DIGITS(DIGITS), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .step_in(step_in), .load_n(load_n), .up(up), .en(en), .d(d),
        .q(q_s), .tc(tc_s), .at_limit(al_s), .bcd(bcd_s), .bcd_valid(bv_s)
    );

    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) * 256) + (((v / 10) % 10) * 16) + (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge: update the model from the inputs present at
    // the edge, then compare the DUT outputs just after it.
    task automatic tick();
        bit evt;
        int n;
        evt = 1'b0;
        if (!rst_n) begin
            m_q[0] = 0; m_q[1] = 0;
            m_tc[0] = 1'b0; m_tc[1] = 1'b0;
            samp.delete();
            repeat (3) samp.push_back(1'b1);
        end else begin
            samp.push_back(step_in);
            n = samp.size();
            // A press first seen at edge k is counted at edge k+2.
            evt = (samp[n-3] == 1'b0) && (samp[n-4] == 1'b1);
            if (n > 8) void'(samp.pop_front());
            for (int i = 0; i < 2; i++) begin
                m_tc[i] = 1'b0;
                if (!load_n) begin
                    m_q[i] = (int'(d) > MODULUS - 1) ? MODULUS - 1 : int'(d);
                end else if (en && evt) begin
                    if (up) begin
                        if (m_q[i] < MODULUS - 1) m_q[i] = m_q[i] + 1;
                        else if (i == 0) begin m_q[i] = 0; m_tc[i] = 1'b1; end
                    end else begin
                        if (m_q[i] > 0) m_q[i] = m_q[i] - 1;
                        else if (i == 0) begin m_q[i] = MODULUS - 1; m_tc[i] = 1'b1; end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("q_wrap", q_w, m_q[0]);
        chk("q_sat", q_s, m_q[1]);
        chk("tc_wrap", tc_w, m_tc[0]);
        chk("tc_sat", tc_s, m_tc[1]);
        chk("at_limit_wrap", al_w, up ? (m_q[0] == MODULUS - 1) : (m_q[0] == 0));
        chk("at_limit_sat", al_s, up ? (m_q[1] == MODULUS - 1) : (m_q[1] == 0));
        if (bv_w === 1'b1) chk("bcd_matches_q_wrap", bcd_w, to_bcd(m_q[0]));
        if (bv_s === 1'b1) chk("bcd_matches_q_sat", bcd_s, to_bcd(m_q[1]));
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic load_val(input int v);
        load_n = 1'b0;
        d = WIDTH'(v);
        tick();
        load_n = 1'b1;
    endtask

    initial begin
        int t;
        rst_n = 1'b0; step_in = 1'b1; load_n = 1'b1; up = 1'b1; en = 1'b1; d = '0;
        samp.delete();
        repeat (3) samp.push_back(1'b1);

        // Reset and release
        settle(2);
        rst_n = 1'b1;
        tick();
        chk("rst_bcd", bcd_w, 12'h000);
        chk("rst_bcd_valid", bv_w, 1'b1);
        chk("rst_tc", tc_w, 1'b0);
        chk("rst_at_limit", al_w, 1'b0);

        // Load 57 and watch the conversion latency
        load_val(57);
        chk("load57_valid_drop", bv_w, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("load57_valid_wait", bv_w, 1'b0);
        end
        tick();
        chk("load57_bcd", bcd_w, 12'h057);
        chk("load57_valid", bv_w, 1'b1);

        // Up-count at the top bound: wrap vs saturate, single count per press
        load_val(199);
        settle(12);
        step_in = 1'b0;
        tick();
        chk("press_k_q", q_w, 199);
        tick();
        chk("press_k1_q", q_w, 199);
        tick();
        chk("wrap_q", q_w, 0);
        chk("wrap_tc", tc_w, 1'b1);
        chk("sat_q", q_s, 199);
        chk("sat_tc", tc_s, 1'b0);
        chk("sat_at_limit", al_s, 1'b1);
        settle(2);
        chk("wrap_tc_one_cycle", tc_w, 1'b0);
        step_in = 1'b1;
        settle(12);
        chk("wrap_bcd", bcd_w, 12'h000);
        chk("wrap_bcd_valid", bv_w, 1'b1);

        // Down-count at zero
        up = 1'b0;
        load_val(0);
        settle(12);
        step_in = 1'b0;
        settle(2);
        step_in = 1'b1;
        tick();
        chk("down_wrap_q", q_w, 199);
        chk("down_wrap_tc", tc_w, 1'b1);
        chk("down_sat_q", q_s, 0);
        settle(10);
        chk("down_bcd", bcd_w, 12'h199);
        chk("down_bcd_valid", bv_w, 1'b1);

        // Load clamp
        up = 1'b1;
        load_val(250);
        chk("clamp_q", q_w, 199);
        settle(12);

        // Load coincident with a step event: load wins, no count
        step_in = 1'b0;
        settle(2);
        step_in = 1'b1;
        load_n = 1'b0;
        d = 8'd33;
        tick();
        load_n = 1'b1;
        chk("load_beats_step", q_w, 33);
        settle(12);
        chk("load_beats_step_bcd", bcd_w, 12'h033);

        // Disabled counting: no change, no pending
        en = 1'b0;
        step_in = 1'b0;
        settle(2);
        step_in = 1'b1;
        settle(4);
        chk("en0_q", q_w, 33);
        chk("en0_valid", bv_w, 1'b1);
        en = 1'b1;

        // Load of the value already held leaves bcd_valid high
        load_val(33);
        chk("same_load_valid", bv_w, 1'b1);
        tick();
        chk("same_load_valid2", bv_w, 1'b1);

        // Three presses four cycles apart from 8: valid held low until
        // the conversion after the last change completes
        load_val(8);
        settle(12);
        for (t = 0; t <= 22; t++) begin
            step_in = ((t % 4) < 2 && t < 12) ? 1'b0 : 1'b1;
            tick();
            if (t >= 2 && t <= 21) chk("burst_valid_low", bv_w, 1'b0);
        end
        chk("burst_bcd", bcd_w, 12'h011);
        chk("burst_valid", bv_w, 1'b1);

        // Reset in the middle of a conversion
        load_val(123);
        settle(3);
        rst_n = 1'b0;
        tick();
        chk("midrst_q", q_w, 0);
        chk("midrst_bcd", bcd_w, 12'h000);
        chk("midrst_valid", bv_w, 1'b1);
        rst_n = 1'b1;
        settle(12);
        chk("midrst_after_valid", bv_w, 1'b1);
        chk("midrst_after_bcd", bcd_w, 12'h000);

        // Randomised traffic against the model, then settle and read back
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 60; i++) begin
                step_in = ($urandom_range(0, 2) != 0);
                load_n  = ($urandom_range(0, 15) != 0);
                d       = WIDTH'($urandom_range(0, 255));
                up      = ($urandom_range(0, 3) != 0) ^ r[0];
                en      = ($urandom_range(0, 7) != 0);
                tick();
            end
            step_in = 1'b1;
            load_n = 1'b1;
            settle(25);
            chk("rand_bcd_wrap", bcd_w, to_bcd(m_q[0]));
            chk("rand_valid_wrap", bv_w, 1'b1);
            chk("rand_bcd_sat", bcd_s, to_bcd(m_q[1]));
            chk("rand_valid_sat", bv_s, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
